// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
package uart_pkg;

   localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;
   localparam int unsigned DEFAULT_BAUD     = 115_200;
   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned STOP_BITS        = 1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional phase accumulator: one-cycle tick_o at an average rate of RATE per second.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
   parameter int unsigned RATE     = DEFAULT_BAUD * 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   logic [31:0] acc_q, acc_d;
   logic        tick_q, tick_d;
   logic [32:0] sum;

   // One spare bit so the add cannot wrap before the compare.
   always_comb begin
      sum    = {1'b0, acc_q} + 33'(RATE);
      tick_d = (sum >= 33'(CLK_FREQ));
      acc_d  = tick_d ? 32'(sum - 33'(CLK_FREQ)) : 32'(sum);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a one-entry read buffer.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
   parameter int unsigned BAUD       = DEFAULT_BAUD,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       sys_clk_i,
   input  logic       sys_rstn_i,
   input  logic       uart_rx_i,
   input  logic       uart_rd_i,
   output logic [7:0] uart_dat_o,
   output logic       uart_valid_o,
   output logic       uart_frame_err_o,
   output logic       uart_overrun_o,
   output logic       uart_busy_o
);

   localparam int unsigned TCW = $clog2(OVERSAMPLE);
   localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2 - 1);
   localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
   localparam logic [2:0]     BI_LAST = 3'(DATA_BITS - 1);

   logic [1:0]     sync_q;
   logic           rx_s;
   logic           tick;

   rx_state_e      state_q, state_d;
   logic [TCW-1:0] tc_q, tc_d;
   logic [2:0]     bi_q, bi_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     dat_q, dat_d;
   logic           valid_q, valid_d;
   logic           ferr_q, ferr_d;
   logic           ovr_q, ovr_d;

   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[0], uart_rx_i};
      end
   end

   assign rx_s = sync_q[1];

   uart_baud_tick #(
      .CLK_FREQ (CLK_FREQ),
      .RATE     (BAUD * OVERSAMPLE)
   ) u_baud_tick (
      .clk_i  (sys_clk_i),
      .rst_ni (sys_rstn_i),
      .tick_o (tick)
   );

   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         state_q <= RX_IDLE;
         tc_q    <= '0;
         bi_q    <= '0;
         shift_q <= '0;
         dat_q   <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
         bi_q    <= bi_d;
         shift_q <= shift_d;
         dat_q   <= dat_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tc_d    = tc_q;
      bi_d    = bi_q;
      shift_d = shift_q;
      dat_d   = dat_q;
      valid_d = valid_q & ~uart_rd_i;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      unique case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               tc_d    = '0;
            end
         end

         RX_START: begin
            if (tick) begin
               if (tc_q == TC_MID) begin
                  if (!rx_s) begin
                     state_d = RX_DATA;
                     tc_d    = '0;
                     bi_d    = '0;
                  end else begin
                     state_d = RX_IDLE;
                  end
               end else begin
                  tc_d = tc_q + TCW'(1);
               end
            end
         end

         RX_DATA: begin
            if (tick) begin
               if (tc_q == TC_LAST) begin
                  shift_d = {rx_s, shift_q[7:1]};
                  tc_d    = '0;
                  if (bi_q == BI_LAST) begin
                     state_d = RX_STOP;
                  end else begin
                     bi_d = bi_q + 3'd1;
                  end
               end else begin
                  tc_d = tc_q + TCW'(1);
               end
            end
         end

         RX_STOP: begin
            if (tick) begin
               if (tc_q == TC_LAST) begin
                  if (rx_s) begin
                     state_d = RX_IDLE;
                     // A read in the delivery cycle frees the slot for the new byte.
                     if (!valid_q || uart_rd_i) begin
                        dat_d   = shift_q;
                        valid_d = 1'b1;
                     end else begin
                        ovr_d = 1'b1;
                     end
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = RX_WAIT_HIGH;
                  end
               end else begin
                  tc_d = tc_q + TCW'(1);
               end
            end
         end

         RX_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end

         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   assign uart_dat_o       = dat_q;
   assign uart_valid_o     = valid_q;
   assign uart_frame_err_o = ferr_q;
   assign uart_overrun_o   = ovr_q;
   assign uart_busy_o      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 cycles per bit (one tick per clock).
module tb_uart_rx;

   localparam int unsigned CLK_FREQ   = 1_600_000;
   localparam int unsigned BAUD       = 100_000;
   localparam int unsigned OVERSAMPLE = 16;
   localparam int          BIT_CYC    = 16;

   logic       clk = 1'b0;
   logic       rstn;
   logic       rx;
   logic       rd;
   logic [7:0] dat;
   logic       valid;
   logic       ferr;
   logic       ovr;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_q[$];

   int ferr_n  = 0;
   int ovr_n   = 0;
   int bfall_n = 0;
   int vfall_n = 0;

   logic       pv;
   logic [7:0] pdat;
   logic       pbusy;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) dut (
      .sys_clk_i        (clk),
      .sys_rstn_i       (rstn),
      .uart_rx_i        (rx),
      .uart_rd_i        (rd),
      .uart_dat_o       (dat),
      .uart_valid_o     (valid),
      .uart_frame_err_o (ferr),
      .uart_overrun_o   (ovr),
      .uart_busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // A load is valid rising, or the held byte changing while valid stays high.
   always @(negedge clk) begin
      if (!rstn) begin
         pv    = 1'b0;
         pdat  = '0;
         pbusy = 1'b0;
      end else begin
         if (valid && (!pv || dat != pdat)) begin
            if (exp_q.size() == 0) begin
               chk("sb_depth", 32'(exp_q.size()), 32'h1);
            end else begin
               chk("rx_dat", 32'(dat), 32'(exp_q.pop_front()));
            end
         end
         if (pv && !valid) vfall_n++;
         if (pbusy && !busy) bfall_n++;
         if (ferr) ferr_n++;
         if (ovr) ovr_n++;
         pv    = valid;
         pdat  = dat;
         pbusy = busy;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      @(posedge clk);
      #1;
      rd = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_cyc);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int c = 0; c < 10 * BIT_CYC; c++) begin
         rx = bits[c / BIT_CYC];
         rd = (c == rd_cyc);
         if (c == 5 * BIT_CYC) chk("busy_mid", 32'(busy), 32'h1);
         @(posedge clk);
         #1;
      end
      rd = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_dat", 32'(dat), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_ferr", 32'(ferr), 32'h0);
      chk("rst_ovr", 32'(ovr), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int f0, o0, o1, b0, v0;
      logic [9:0] bits;

      rx   = 1'b1;
      rd   = 1'b0;
      rstn = 1'b0;
      idle(5);
      chk_reset_vals();
      rstn = 1'b1;
      idle(5);

      // 1: single frame, then read
      f0 = ferr_n; o0 = ovr_n;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1);
      chk("t1_valid", 32'(valid), 32'h1);
      chk("t1_dat", 32'(dat), 32'hA5);
      chk("t1_ferr", 32'(ferr_n - f0), 32'h0);
      chk("t1_ovr", 32'(ovr_n - o0), 32'h0);
      pulse_rd();
      chk("t1_cleared", 32'(valid), 32'h0);
      idle(4);

      // 2: back-to-back frames with reads
      b0 = bfall_n;
      exp_q.push_back(8'h00);
      send_frame(8'h00, 1'b1, 157);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, 157);
      idle(4);
      chk("t2_busy_falls", 32'(bfall_n - b0), 32'h2);
      chk("t2_valid", 32'(valid), 32'h0);
      chk("t2_sb", 32'(exp_q.size()), 32'h0);

      // 3: start-bit glitch
      b0 = bfall_n; f0 = ferr_n; o0 = ovr_n;
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(30);
      chk("t3_valid", 32'(valid), 32'h0);
      chk("t3_busy", 32'(busy), 32'h0);
      chk("t3_busy_falls", 32'(bfall_n - b0), 32'h1);
      chk("t3_ferr", 32'(ferr_n - f0), 32'h0);
      chk("t3_ovr", 32'(ovr_n - o0), 32'h0);

      // 4: framing error, held-low line, recovery
      f0 = ferr_n;
      send_frame(8'h3C, 1'b0, -1);
      idle(40);
      chk("t4_wait_busy", 32'(busy), 32'h1);
      chk("t4_ferr", 32'(ferr_n - f0), 32'h1);
      chk("t4_valid", 32'(valid), 32'h0);
      rx = 1'b1;
      idle(4);
      chk("t4_idle", 32'(busy), 32'h0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, -1);
      chk("t4_valid2", 32'(valid), 32'h1);
      chk("t4_dat2", 32'(dat), 32'h5A);
      chk("t4_ferr2", 32'(ferr_n - f0), 32'h1);
      pulse_rd();
      idle(4);

      // 5: overrun, then read coincident with delivery
      o0 = ovr_n;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1);
      send_frame(8'h22, 1'b1, -1);
      chk("t5_dat", 32'(dat), 32'h11);
      chk("t5_valid", 32'(valid), 32'h1);
      chk("t5_ovr", 32'(ovr_n - o0), 32'h1);
      pulse_rd();
      chk("t5_cleared", 32'(valid), 32'h0);
      idle(4);
      o1 = ovr_n; v0 = vfall_n;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1, -1);
      exp_q.push_back(8'h22);
      send_frame(8'h22, 1'b1, 154);
      chk("t5b_dat", 32'(dat), 32'h22);
      chk("t5b_valid", 32'(valid), 32'h1);
      chk("t5b_ovr", 32'(ovr_n - o1), 32'h0);
      chk("t5b_vfall", 32'(vfall_n - v0), 32'h0);
      idle(2);

      // 6: reset during data bit 4 with a full buffer, then a clean frame
      bits = {1'b1, 8'h96, 1'b0};
      for (int c = 0; c < 5 * BIT_CYC + BIT_CYC / 2; c++) begin
         rx = bits[c / BIT_CYC];
         @(posedge clk);
         #1;
      end
      rstn = 1'b0;
      rx   = 1'b1;
      #1;
      chk_reset_vals();
      idle(3);
      chk_reset_vals();
      rstn = 1'b1;
      idle(5);
      exp_q.push_back(8'h96);
      send_frame(8'h96, 1'b1, -1);
      chk("t6_valid", 32'(valid), 32'h1);
      chk("t6_dat", 32'(dat), 32'h96);
      pulse_rd();
      idle(5);

      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the receive-side counterpart of the existing 8N1 transmitter. It sits between the board RX pin and the core's MMIO/console logic. Frame format is 1 start bit, 8 data bits LSB first, 1 stop bit, no parity, 115200 baud from a 100 MHz system clock by default. Each received byte is held in a one-entry buffer with a valid/read handshake, and framing and overrun errors are reported as pulses.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit. Must be an even value ≥ 8.

Ports:
- sys_clk_i  in  1  system clock.
- sys_rstn_i  in  1  reset. Asynchronous, active-low; the design has one clock and an asynchronous active-low reset.
- uart_rx_i  in  1  serial line. Asynchronous to sys_clk_i; idles high.
- uart_rd_i  in  1  consumer has taken the byte. Clears uart_valid_o.
- uart_dat_o  out  8  received byte. Stable while uart_valid_o=1.
- uart_valid_o  out  1  buffer holds an unread byte. Level signal.
- uart_frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- uart_overrun_o  out  1  one-cycle pulse: a byte completed while the buffer was full.
- uart_busy_o  out  1  receiver FSM is not IDLE.

## Operation
- **Synchronizer.** uart_rx_i passes through a 2-FF synchronizer; both flops reset to 1. All logic below uses only the synchronized signal `rx_s`.
- **Tick generator.** A free-running fractional phase accumulator.
  - Each cycle: acc += BAUD*OVERSAMPLE.
  - When acc ≥ CLK_FREQ: emit a one-cycle `tick` and subtract CLK_FREQ.
  - Width: 32 bits unsigned. Resets to 0.
  - Average tick rate is exact, with jitter of at most 1 cycle.
- **FSM states.** IDLE, START, DATA, STOP, WAIT_HIGH. Resets to IDLE. A tick counter `tc` (log2 OVERSAMPLE bits) and a bit index `bi` (3 bits) both reset to 0.
  - **IDLE:** when rx_s=0, go to START with tc=0. Not gated by tick.
  - **START:** count ticks. On the tick where tc reaches OVERSAMPLE/2−1 (mid start bit), sample rx_s.
    - 0: go to DATA with tc=0, bi=0.
    - 1: glitch; return to IDLE with no error.
  - **DATA:** on the tick where tc reaches OVERSAMPLE−1, shift rx_s into the MSB of the shift register (LSB-first arrival) and reset tc to 0.
    - After bi=7, go to STOP; otherwise bi+1.
  - **STOP:** at tc=OVERSAMPLE−1, sample rx_s.
    - 1: deliver the byte (see below) and go to IDLE.
    - 0: pulse uart_frame_err_o, discard the byte, go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until rx_s=1, then go to IDLE. This covers break conditions so a held-low line is not re-read as start bits.
- **Deliver, buffer empty** (uart_valid_o=0, or uart_rd_i=1 in the same cycle): load uart_dat_o and set uart_valid_o=1.
- **Deliver, buffer full** (uart_valid_o=1 and uart_rd_i=0): keep the old byte, drop the new one, and pulse uart_overrun_o.
- **uart_rd_i** with uart_valid_o=1 clears valid next cycle. It is ignored when valid=0.
- **uart_rd_i and delivery in the same cycle:** the new byte is loaded, valid stays 1, and there is no overrun.

## Timing
- **Reset values:** uart_dat_o=0x00, uart_valid_o=0, uart_frame_err_o=0, uart_overrun_o=0, uart_busy_o=0.
- **Reset mid-frame:** aborts the frame immediately. No pulse is generated, and the buffer is cleared.
- **Synchronizer latency:** 2 cycles from pin to rx_s.
- **Start detection:** the IDLE→START transition occurs the cycle after rx_s falls.
- **Delivery latency:** valid, or an error pulse, is registered 1 cycle after the stop-bit sampling tick.
- **Pulses:** all pulse outputs are exactly one cycle and registered.
- **Back-to-back frames:** a start bit immediately following the stop sample is accepted. IDLE→START needs no tick, so residual delay is ≤ OVERSAMPLE/2 ticks.
- **Baud tolerance:** with OVERSAMPLE=16 the receiver tolerates about ±4% baud mismatch.

## Structure
- **Package `uart_pkg`:** rx FSM state enum, DEFAULT_CLK_FREQ and DEFAULT_BAUD constants, and the frame constants DATA_BITS=8 and STOP_BITS=1.
- **Sub-module `uart_baud_tick`:** the tick generator, parameterized on CLK_FREQ and RATE, with a single `tick_o` output. It is reusable later to move the transmitter onto the same generator.
- **uart_rx itself:** synchronizer, FSM, shift register, output buffer.

## Test plan
Use CLK_FREQ=1_600_000, BAUD=100_000, OVERSAMPLE=16. This gives 1 tick per cycle and 16 cycles per bit.
1. Frame for 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) → uart_valid_o rises 1 cycle after the stop-bit sample with uart_dat_o=0xA5 and no error pulses. After a uart_rd_i pulse, valid=0.
2. Back-to-back frames 0x00 then 0xFF, with uart_rd_i pulsed after each → both bytes delivered in order, and busy drops only between frames.
3. Line held low for 3 ticks then high (glitch) → FSM returns to IDLE, valid stays 0, no error pulses.
4. Frame 0x3C with stop bit driven 0, line low for 40 further cycles, then frame 0x5A → one uart_frame_err_o pulse, 0x3C not delivered, FSM holds WAIT_HIGH until the line goes high, then 0x5A delivered.
5. Frames 0x11 then 0x22 without uart_rd_i → uart_dat_o stays 0x11 and one uart_overrun_o pulse occurs. Repeat with uart_rd_i asserted in the delivery cycle of 0x22 → dat=0x22, valid stays 1, no overrun.
6. sys_rstn_i asserted during data bit 4 of 0x96, released, then frame 0x96 sent → all outputs at reset values during reset, then 0x96 received cleanly.
